// File: rtl/palette_load_ctrl.sv
// Palette upload sequencer: packs an R,G,B byte stream into 24-bit entries and
// writes them into the shared palette RAM only while its port is free.
module palette_load_ctrl #(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    input  logic             vblank,
    input  logic             force_wr,
    output logic             load_color,
    output logic [IDX_W-1:0] load_color_index,
    output logic [23:0]      load_color_data,
    output logic             busy,
    output logic             done,
    output logic             pal_valid,
    output logic             overflow
);

    typedef enum logic [2:0] {
        IDLE,
        GATHER,
        WAIT_WIN,
        WRITE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [23:0]      data_q, data_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pv_q, pv_d;
    logic             ovf_q, ovf_d;
    logic             accept;

    // A start pulse always wins, so no byte may be taken in its cycle.
    assign byte_ready = reset_n & ~start &
                        ((state_q == IDLE) | (state_q == GATHER) | (state_q == DONE));
    assign accept     = byte_valid & byte_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        pv_d    = pv_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // Bytes arriving after a completed upload still count as overflow.
                if (accept && pv_q) begin
                    ovf_d = 1'b1;
                end
            end
            GATHER: begin
                if (accept) begin
                    data_d = {data_q[15:0], byte_data};
                    if (cnt_q == 2'd2) begin
                        cnt_d   = 2'd0;
                        state_d = WAIT_WIN;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            WAIT_WIN: begin
                if (vblank || force_wr) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pv_d    = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = GATHER;
                end
            end
            DONE: begin
                if (accept) begin
                    ovf_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = GATHER;
            cnt_d   = 2'd0;
            idx_d   = '0;
            data_d  = '0;
            pv_d    = 1'b0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
        end
    end

    // Strobe and busy are decoded from the next state so they come straight off flops.
    assign load_d = (state_d == WRITE);
    assign busy_d = (state_d == GATHER) || (state_d == WAIT_WIN) || (state_d == WRITE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign load_color       = load_q;
    assign load_color_index = idx_q;
    assign load_color_data  = data_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pal_valid        = pv_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_palette_load_ctrl.sv
// Directed bench for palette_load_ctrl: vector table for the gating/restart
// corners, plus hand sequences for full uploads, overflow and reset in WRITE.
module tb_palette_load_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        vblank;
    logic        force_wr;
    logic        load_color;
    logic [5:0]  load_color_index;
    logic [23:0] load_color_data;
    logic        busy;
    logic        done;
    logic        pal_valid;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    palette_load_ctrl #(.ENTRIES(64), .IDX_W(6)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .vblank           (vblank),
        .force_wr         (force_wr),
        .load_color       (load_color),
        .load_color_index (load_color_index),
        .load_color_data  (load_color_data),
        .busy             (busy),
        .done             (done),
        .pal_valid        (pal_valid),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  d;
        logic        vb;
        logic        fw;
        logic        e_rdy;
        logic        e_ld;
        logic [5:0]  e_idx;
        logic [23:0] e_dat;
        logic        e_busy;
        logic        e_done;
        logic        e_pv;
        logic        e_ovf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_row(input int i, input vec_t v);
        start      = v.st;
        byte_valid = v.vld;
        byte_data  = v.d;
        vblank     = v.vb;
        force_wr   = v.fw;
        #1;
        chk($sformatf("row%0d_ready", i), byte_ready, v.e_rdy);
        @(posedge clk); #1;
        chk($sformatf("row%0d_load", i), load_color, v.e_ld);
        chk($sformatf("row%0d_idx", i), load_color_index, v.e_idx);
        chk($sformatf("row%0d_data", i), load_color_data, v.e_dat);
        chk($sformatf("row%0d_busy", i), busy, v.e_busy);
        chk($sformatf("row%0d_done", i), done, v.e_done);
        chk($sformatf("row%0d_pv", i), pal_valid, v.e_pv);
        chk($sformatf("row%0d_ovf", i), overflow, v.e_ovf);
        $display("row %0d: ready=%0b load=%0b idx=%0d data=%06h busy=%0b",
                 i, byte_ready, load_color, load_color_index, load_color_data, busy);
    endtask

    // Full 64-entry upload with valid held high; returns in the cycle done is seen.
    task automatic run_upload(input string tag, input logic vb, input logic fw);
        int  nb;
        int  k;
        int  last_w;
        int  dones;
        logic acc;
        vblank     = vb;
        force_wr   = fw;
        byte_valid = 1'b0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_start_pv"}, pal_valid, 1'b0);
        chk({tag, "_start_ovf"}, overflow, 1'b0);
        chk({tag, "_start_busy"}, busy, 1'b1);
        chk({tag, "_start_idx"}, load_color_index, 6'd0);
        nb = 0; k = 0; last_w = -1; dones = 0;
        for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
            byte_valid = (nb < 192);
            byte_data  = 8'(nb);
            #1;
            acc = byte_valid & byte_ready;
            @(posedge clk); #1;
            if (acc) nb++;
            if (load_color) begin
                chk({tag, "_wr_idx"}, load_color_index, k[5:0]);
                chk({tag, "_wr_data"}, load_color_data, {8'(3*k), 8'(3*k+1), 8'(3*k+2)});
                if (last_w >= 0) chk({tag, "_cadence"}, cyc - last_w, 5);
                last_w = cyc;
                k++;
            end
            if (done) dones++;
        end
        byte_valid = 1'b0;
        chk({tag, "_writes"}, k, 64);
        chk({tag, "_bytes"}, nb, 192);
        chk({tag, "_done_seen"}, dones, 1);
        chk({tag, "_pv"}, pal_valid, 1'b1);
        chk({tag, "_busy_low"}, busy, 1'b0);
        chk({tag, "_last_idx"}, load_color_index, 6'd63);
        $display("upload %s: writes=%0d bytes=%0d done=%0d pal_valid=%0b", tag, k, nb, dones, pal_valid);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // {st,vld,d,vb,fw, e_rdy,e_ld,e_idx,e_dat,e_busy,e_done,e_pv,e_ovf}
        vecs[0]  = '{1, 1, 8'h55, 0, 0, 0, 0, 6'd0, 24'h000000, 1, 0, 0, 0};
        vecs[1]  = '{0, 1, 8'h11, 0, 0, 1, 0, 6'd0, 24'h000011, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 8'h22, 0, 0, 1, 0, 6'd0, 24'h001122, 1, 0, 0, 0};
        vecs[3]  = '{0, 1, 8'h33, 0, 0, 1, 0, 6'd0, 24'h112233, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 8'h44, 0, 0, 0, 0, 6'd0, 24'h112233, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 8'h44, 0, 0, 0, 0, 6'd0, 24'h112233, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 8'h00, 1, 0, 0, 1, 6'd0, 24'h112233, 1, 0, 0, 0};
        vecs[7]  = '{0, 0, 8'h00, 0, 0, 0, 0, 6'd1, 24'h112233, 1, 0, 0, 0};
        vecs[8]  = '{0, 1, 8'h44, 0, 0, 1, 0, 6'd1, 24'h223344, 1, 0, 0, 0};
        vecs[9]  = '{1, 1, 8'h99, 0, 0, 0, 0, 6'd0, 24'h000000, 1, 0, 0, 0};
        vecs[10] = '{0, 1, 8'hAA, 0, 1, 1, 0, 6'd0, 24'h0000AA, 1, 0, 0, 0};
        vecs[11] = '{0, 1, 8'hBB, 0, 1, 1, 0, 6'd0, 24'h00AABB, 1, 0, 0, 0};
        vecs[12] = '{0, 1, 8'hCC, 0, 1, 1, 0, 6'd0, 24'hAABBCC, 1, 0, 0, 0};
        vecs[13] = '{0, 0, 8'h00, 0, 1, 0, 1, 6'd0, 24'hAABBCC, 1, 0, 0, 0};
        vecs[14] = '{0, 0, 8'h00, 0, 0, 0, 0, 6'd1, 24'hAABBCC, 1, 0, 0, 0};

        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        vblank = 1'b0; force_wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", byte_ready, 1'b0);
        chk("rst_load", load_color, 1'b0);
        chk("rst_idx", load_color_index, 6'd0);
        chk("rst_data", load_color_data, 24'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pv", pal_valid, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", byte_ready, 1'b1);
        $display("reset: outputs idle, byte_ready=%0b", byte_ready);

        for (int i = 0; i < 15; i++) apply_row(i, vecs[i]);

        // Full upload in vertical blank, then overflow bytes while in DONE.
        run_upload("vb", 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'hE0 + 8'(i);
            #1;
            chk("ovf_ready", byte_ready, 1'b1);
            @(posedge clk); #1;
            chk("ovf_done_once", done, 1'b0);
            chk("ovf_flag", overflow, 1'b1);
            chk("ovf_pv", pal_valid, 1'b1);
            chk("ovf_no_write", load_color, 1'b0);
            $display("extra byte %0d: overflow=%0b pal_valid=%0b", i, overflow, pal_valid);
        end
        byte_valid = 1'b0;
        @(posedge clk); #1;
        chk("ovf_sticky", overflow, 1'b1);

        // Forced upload with vblank low; its start must clear overflow and pal_valid.
        run_upload("fw", 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("fw_done_once", done, 1'b0);
        chk("fw_pv_hold", pal_valid, 1'b1);

        // Reset asserted while the write strobe is high.
        start = 1'b1; force_wr = 1'b1; vblank = 1'b0; byte_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1'b1;
            byte_data  = 8'h70 + 8'(i);
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        for (int i = 0; i < 10 && !load_color; i++) begin
            @(posedge clk); #1;
        end
        chk("arst_write_reached", load_color, 1'b1);
        chk("arst_write_data", load_color_data, 24'h707172);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_load", load_color, 1'b0);
        chk("arst_ready", byte_ready, 1'b0);
        chk("arst_data", load_color_data, 24'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_pv", pal_valid, 1'b0);
        $display("async reset in WRITE: load_color=%0b busy=%0b", load_color, busy);
        @(posedge clk); #1;
        reset_n = 1'b1;
        force_wr = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_load", load_color, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
